regfile_scoreboard: RTL and testbench

Parametrised general-purpose register file for the MISC-V datapath. It has N combinational read ports, one write port and a per-register busy scoreboard for pipeline hazard detection. Register 0 is hardwired to zero. Writes commit on the rising edge, and a same-cycle write is forwarded to matching read ports when bypass is enabled. It sits between decode (reads, claims) and writeback (writes, releases).

---
 rtl/regfile_scoreboard.sv | 96 +++++++++
 tb/tb_regfile_scoreboard.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with N combinational read ports, one write port and a per-register busy scoreboard.
// Latency: reads 0 cycles; writes and claims visible after the edge (writes/releases forwarded same cycle when BYPASS=1).
// Backpressure: none; hazards are reported on Reg_busy and the consumer is expected to stall on it.
module regfile_scoreboard #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NUM_RD = 3,
  parameter int BYPASS = 1
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       Reg_Write,
  input  logic [ADDR_W-1:0]          Reg_input_address,
  input  logic [DATA_W-1:0]          Reg_input_data,
  input  logic                       Claim,
  input  logic [ADDR_W-1:0]          Claim_address,
  input  logic [NUM_RD*ADDR_W-1:0]   Reg_address,
  output logic [NUM_RD*DATA_W-1:0]   Reg_output,
  output logic [NUM_RD-1:0]          Reg_busy,
  output logic [(1<<ADDR_W)-1:0]     Busy_vector,
  output logic                       Write_unclaimed
);

  localparam int NREG = 1 << ADDR_W;

  // Entry 0 has no storage; it only exists in the read views below.
  logic [DATA_W-1:0] regs [NREG-1:1];
  logic [NREG-1:1]   busy_q;
  logic              write_unclaimed_q;

  logic              wr_hit;
  logic              claim_hit;
  logic              fwd_en;
  logic [DATA_W-1:0] regs_view [NREG];
  logic [NREG-1:0]   busy_view;

  assign wr_hit    = Reg_Write && !Reset && (Reg_input_address != '0);
  assign claim_hit = Claim && !Reset && (Claim_address != '0);
  assign fwd_en    = (BYPASS != 0) && wr_hit;

  assign busy_view       = {busy_q, 1'b0};
  assign Busy_vector     = busy_view;
  assign Write_unclaimed = write_unclaimed_q;

  // Register storage, scoreboard and sticky unclaimed-write flag; claim beats release on the same register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int r = 1; r < NREG; r++) begin
        regs[r] <= '0;
      end
      busy_q            <= '0;
      write_unclaimed_q <= 1'b0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (wr_hit && (Reg_input_address == ADDR_W'(r))) begin
          regs[r] <= Reg_input_data;
        end
        if (claim_hit && (Claim_address == ADDR_W'(r))) begin
          busy_q[r] <= 1'b1;
        end else if (wr_hit && (Reg_input_address == ADDR_W'(r))) begin
          busy_q[r] <= 1'b0;
        end
      end
      if (wr_hit && !busy_view[Reg_input_address]) begin
        write_unclaimed_q <= 1'b1;
      end
    end
  end

  // Flat read view with the hardwired zero entry at index 0.
  always_comb begin
    regs_view[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      regs_view[r] = regs[r];
    end
  end

  // Independent read ports: r0 reads zero/not-busy, a same-cycle write forwards data and clears busy.
  always_comb begin
    Reg_output = '0;
    Reg_busy   = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (Reg_address[p*ADDR_W +: ADDR_W] == '0) begin
        Reg_output[p*DATA_W +: DATA_W] = '0;
        Reg_busy[p]                    = 1'b0;
      end else if (fwd_en && (Reg_input_address == Reg_address[p*ADDR_W +: ADDR_W])) begin
        Reg_output[p*DATA_W +: DATA_W] = Reg_input_data;
        Reg_busy[p]                    = 1'b0;
      end else begin
        Reg_output[p*DATA_W +: DATA_W] = regs_view[Reg_address[p*ADDR_W +: ADDR_W]];
        Reg_busy[p]                    = busy_view[Reg_address[p*ADDR_W +: ADDR_W]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, random run against a register/scoreboard model, wide-parameter sequence.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled 2 units later.
// Backpressure: not applicable.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the BYPASS=1 and BYPASS=0 instances (default widths).
  logic        rst, we, cl;
  logic [2:0]  wa, ca;
  logic [15:0] wd;
  logic [8:0]  raddr;
  logic [47:0] out_b, out_n;
  logic [2:0]  busy_b, busy_n;
  logic [7:0]  bv_b, bv_n;
  logic        wu_b, wu_n;

  // Wide instance.
  logic         w_rst, w_we, w_cl;
  logic [3:0]   w_wa, w_ca;
  logic [31:0]  w_wd;
  logic [15:0]  w_raddr;
  logic [127:0] w_out;
  logic [3:0]   w_busy;
  logic [15:0]  w_bv;
  logic         w_wu;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_scoreboard #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3), .BYPASS(1)) u_byp (
    .CLK(clk), .Reset(rst), .Reg_Write(we), .Reg_input_address(wa), .Reg_input_data(wd),
    .Claim(cl), .Claim_address(ca), .Reg_address(raddr), .Reg_output(out_b),
    .Reg_busy(busy_b), .Busy_vector(bv_b), .Write_unclaimed(wu_b));

  regfile_scoreboard #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3), .BYPASS(0)) u_nob (
    .CLK(clk), .Reset(rst), .Reg_Write(we), .Reg_input_address(wa), .Reg_input_data(wd),
    .Claim(cl), .Claim_address(ca), .Reg_address(raddr), .Reg_output(out_n),
    .Reg_busy(busy_n), .Busy_vector(bv_n), .Write_unclaimed(wu_n));

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(4), .NUM_RD(4), .BYPASS(1)) u_wide (
    .CLK(clk), .Reset(w_rst), .Reg_Write(w_we), .Reg_input_address(w_wa), .Reg_input_data(w_wd),
    .Claim(w_cl), .Claim_address(w_ca), .Reg_address(w_raddr), .Reg_output(w_out),
    .Reg_busy(w_busy), .Busy_vector(w_bv), .Write_unclaimed(w_wu));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One directed cycle: inputs, then expected outputs seen before the edge (all read ports use the same address).
  typedef struct {
    logic        rst, we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        cl;
    logic [2:0]  ca, ra;
    logic [15:0] eb, en;   // port data, bypass / no-bypass instance
    logic        kb, kn;   // port busy, bypass / no-bypass instance
    logic [7:0]  bv;
    logic        wu;
    logic        chk;
  } vec_t;

  function automatic vec_t mk(logic r, logic w, logic [2:0] a, logic [15:0] d, logic c, logic [2:0] cadr,
                              logic [2:0] ra, logic [15:0] eb, logic [15:0] en, logic kb, logic kn,
                              logic [7:0] bv, logic wu, logic chk);
    vec_t v;
    v.rst = r; v.we = w; v.wa = a; v.wd = d; v.cl = c; v.ca = cadr; v.ra = ra;
    v.eb = eb; v.en = en; v.kb = kb; v.kn = kn; v.bv = bv; v.wu = wu; v.chk = chk;
    return v;
  endfunction

  vec_t vt[28];

  // Behavioural model of register contents and outstanding producers.
  logic [15:0] m_regs [8];
  logic        m_busy [8];
  logic        m_wu;

  initial begin
    //         rst we wa  wd       cl ca ra  eb       en       kb kn bv     wu chk
    vt[0]  = mk(1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 8'h00, 0, 0);
    vt[1]  = mk(0, 1, 5, 16'hBEEF, 0, 0, 5, 16'hBEEF, 16'h0000, 0, 0, 8'h00, 0, 1);
    vt[2]  = mk(0, 0, 0, 16'h0000, 0, 0, 5, 16'hBEEF, 16'hBEEF, 0, 0, 8'h00, 1, 1);
    vt[3]  = mk(1, 0, 0, 16'h0000, 0, 0, 5, 16'hBEEF, 16'hBEEF, 0, 0, 8'h00, 1, 1);
    vt[4]  = mk(0, 0, 0, 16'h0000, 0, 0, 5, 16'h0000, 16'h0000, 0, 0, 8'h00, 0, 1);
    vt[5]  = mk(0, 1, 3, 16'h1234, 0, 0, 3, 16'h1234, 16'h0000, 0, 0, 8'h00, 0, 1);
    vt[6]  = mk(0, 0, 0, 16'h0000, 0, 0, 3, 16'h1234, 16'h1234, 0, 0, 8'h00, 1, 1);
    vt[7]  = mk(1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 8'h00, 1, 1);
    vt[8]  = mk(0, 1, 0, 16'hFFFF, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 8'h00, 0, 1);
    vt[9]  = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 8'h00, 0, 1);
    vt[10] = mk(0, 0, 0, 16'h0000, 1, 2, 2, 16'h0000, 16'h0000, 0, 0, 8'h00, 0, 1);
    vt[11] = mk(0, 0, 0, 16'h0000, 0, 0, 2, 16'h0000, 16'h0000, 1, 1, 8'h04, 0, 1);
    vt[12] = mk(0, 0, 0, 16'h0000, 0, 0, 2, 16'h0000, 16'h0000, 1, 1, 8'h04, 0, 1);
    vt[13] = mk(0, 1, 2, 16'h00AA, 1, 2, 2, 16'h00AA, 16'h0000, 0, 1, 8'h04, 0, 1);
    vt[14] = mk(0, 0, 0, 16'h0000, 0, 0, 2, 16'h00AA, 16'h00AA, 1, 1, 8'h04, 0, 1);
    vt[15] = mk(0, 1, 2, 16'h0055, 0, 0, 2, 16'h0055, 16'h00AA, 0, 1, 8'h04, 0, 1);
    vt[16] = mk(0, 0, 0, 16'h0000, 0, 0, 2, 16'h0055, 16'h0055, 0, 0, 8'h00, 0, 1);
    vt[17] = mk(0, 1, 6, 16'h0042, 0, 0, 6, 16'h0042, 16'h0000, 0, 0, 8'h00, 0, 1);
    vt[18] = mk(0, 0, 0, 16'h0000, 0, 0, 6, 16'h0042, 16'h0042, 0, 0, 8'h00, 1, 1);
    vt[19] = mk(0, 0, 0, 16'h0000, 0, 0, 6, 16'h0042, 16'h0042, 0, 0, 8'h00, 1, 1);
    vt[20] = mk(0, 0, 0, 16'h0000, 1, 4, 4, 16'h0000, 16'h0000, 0, 0, 8'h00, 1, 1);
    vt[21] = mk(1, 0, 0, 16'h0000, 0, 0, 4, 16'h0000, 16'h0000, 1, 1, 8'h10, 1, 1);
    vt[22] = mk(0, 1, 4, 16'h0777, 0, 0, 4, 16'h0777, 16'h0000, 0, 0, 8'h00, 0, 1);
    vt[23] = mk(0, 0, 0, 16'h0000, 0, 0, 4, 16'h0777, 16'h0777, 0, 0, 8'h00, 1, 1);
    vt[24] = mk(0, 1, 7, 16'h7777, 1, 1, 7, 16'h7777, 16'h0000, 0, 0, 8'h00, 1, 1);
    vt[25] = mk(0, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000, 1, 1, 8'h02, 1, 1);
    vt[26] = mk(1, 1, 7, 16'h1111, 0, 0, 7, 16'h7777, 16'h7777, 0, 0, 8'h02, 1, 1);
    vt[27] = mk(0, 0, 0, 16'h0000, 0, 0, 7, 16'h0000, 16'h0000, 0, 0, 8'h00, 0, 1);

    w_rst = 1'b1; w_we = 1'b0; w_cl = 1'b0; w_wa = '0; w_ca = '0; w_wd = '0; w_raddr = '0;

    // Directed table.
    for (int i = 0; i < 28; i++) begin
      rst = vt[i].rst; we = vt[i].we; wa = vt[i].wa; wd = vt[i].wd;
      cl = vt[i].cl; ca = vt[i].ca; raddr = {3{vt[i].ra}};
      #2;
      if (vt[i].chk) begin
        for (int p = 0; p < 3; p++) begin
          chk($sformatf("row%0d_p%0d_data_byp", i, p), 64'(out_b[p*16 +: 16]), 64'(vt[i].eb));
          chk($sformatf("row%0d_p%0d_data_nob", i, p), 64'(out_n[p*16 +: 16]), 64'(vt[i].en));
          chk($sformatf("row%0d_p%0d_busy_byp", i, p), 64'(busy_b[p]), 64'(vt[i].kb));
          chk($sformatf("row%0d_p%0d_busy_nob", i, p), 64'(busy_n[p]), 64'(vt[i].kn));
        end
        chk($sformatf("row%0d_bv_byp", i), 64'(bv_b), 64'(vt[i].bv));
        chk($sformatf("row%0d_bv_nob", i), 64'(bv_n), 64'(vt[i].bv));
        chk($sformatf("row%0d_wu_byp", i), 64'(wu_b), 64'(vt[i].wu));
        chk($sformatf("row%0d_wu_nob", i), 64'(wu_n), 64'(vt[i].wu));
      end
      step();
    end

    // Random run against the model; iteration 0 is a reset so the model starts in sync.
    for (int it = 0; it < 400; it++) begin
      rst   = (it == 0) || ($urandom_range(0, 49) == 0);
      we    = 1'($urandom_range(0, 1));
      wa    = 3'($urandom);
      wd    = 16'($urandom);
      cl    = ($urandom_range(0, 2) == 0);
      ca    = 3'($urandom);
      raddr = 9'($urandom);
      if ($urandom_range(0, 3) == 0) raddr[2:0] = wa;
      #2;
      if (it > 0) begin
        logic [7:0] exp_bv;
        for (int p = 0; p < 3; p++) begin
          logic [2:0]  a;
          logic [15:0] ed_b, ed_n;
          logic        eb_b, eb_n;
          a = raddr[p*3 +: 3];
          if (a == 0) begin
            ed_n = 16'h0; eb_n = 1'b0;
          end else begin
            ed_n = m_regs[a]; eb_n = m_busy[a];
          end
          ed_b = ed_n; eb_b = eb_n;
          if (a != 0 && we && !rst && wa == a) begin
            ed_b = wd; eb_b = 1'b0;
          end
          chk($sformatf("rnd%0d_p%0d_data_byp", it, p), 64'(out_b[p*16 +: 16]), 64'(ed_b));
          chk($sformatf("rnd%0d_p%0d_data_nob", it, p), 64'(out_n[p*16 +: 16]), 64'(ed_n));
          chk($sformatf("rnd%0d_p%0d_busy_byp", it, p), 64'(busy_b[p]), 64'(eb_b));
          chk($sformatf("rnd%0d_p%0d_busy_nob", it, p), 64'(busy_n[p]), 64'(eb_n));
        end
        exp_bv = '0;
        for (int r = 1; r < 8; r++) exp_bv[r] = m_busy[r];
        chk($sformatf("rnd%0d_bv_byp", it), 64'(bv_b), 64'(exp_bv));
        chk($sformatf("rnd%0d_bv_nob", it), 64'(bv_n), 64'(exp_bv));
        chk($sformatf("rnd%0d_wu_byp", it), 64'(wu_b), 64'(m_wu));
        chk($sformatf("rnd%0d_wu_nob", it), 64'(wu_n), 64'(m_wu));
      end
      // Model update for this edge: release first, then a claim overrides it.
      if (rst) begin
        for (int r = 0; r < 8; r++) begin
          m_regs[r] = '0; m_busy[r] = 1'b0;
        end
        m_wu = 1'b0;
      end else begin
        if (we && wa != 0) begin
          if (!m_busy[wa]) m_wu = 1'b1;
          m_regs[wa] = wd;
          m_busy[wa] = 1'b0;
        end
        if (cl && ca != 0) m_busy[ca] = 1'b1;
      end
      step();
    end
    rst = 1'b0; we = 1'b0; cl = 1'b0;

    // Wide instance: all four ports on r15, then reset racing a write.
    w_raddr = {4{4'hF}};
    step();
    w_rst = 1'b0; w_we = 1'b1; w_wa = 4'hF; w_wd = 32'hDEADBEEF;
    #2;
    for (int p = 0; p < 4; p++) chk($sformatf("wide_fwd_p%0d", p), 64'(w_out[p*32 +: 32]), 64'h0000_0000_DEAD_BEEF);
    step();
    w_we = 1'b0;
    #2;
    for (int p = 0; p < 4; p++) chk($sformatf("wide_rd_p%0d", p), 64'(w_out[p*32 +: 32]), 64'h0000_0000_DEAD_BEEF);
    chk("wide_wu_set", 64'(w_wu), 64'h1);
    step();
    w_rst = 1'b1; w_we = 1'b1; w_wd = 32'h12345678;
    #2;
    for (int p = 0; p < 4; p++) chk($sformatf("wide_rst_nofwd_p%0d", p), 64'(w_out[p*32 +: 32]), 64'h0000_0000_DEAD_BEEF);
    step();
    w_rst = 1'b0; w_we = 1'b0;
    #2;
    for (int p = 0; p < 4; p++) chk($sformatf("wide_after_rst_p%0d", p), 64'(w_out[p*32 +: 32]), 64'h0);
    chk("wide_wu_clr", 64'(w_wu), 64'h0);
    chk("wide_bv_clr", 64'(w_bv), 64'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
